// File: rtl/cpu_axi_bridge_if.sv
// AXI bus bundle shared by the CPU side (AXI3 flavour: 4-bit len, 2-bit lock, wid)
// and the fabric side (AXI4 flavour: 8-bit len, 1-bit lock), sized by LEN_W/LOCK_W.
// Ports: AW, W, B, AR and R channels. The master modport drives valid/payload and
// ready on B/R. The slave modport is the mirror image. On the AXI4 side, wid is unused.
interface cpu_axi_bridge_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int LOCK_W = 1
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [LEN_W-1:0]    awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [LOCK_W-1:0]   awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid, awready;

  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast, wvalid, wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid, bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [LEN_W-1:0]    arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [LOCK_W-1:0]   arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid, arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast, rvalid, rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/cpu_axi_bridge.sv
// CPU AXI3 master -> AXI4 fabric bridge: outstanding limiter per direction, W buffer, IRQ sync.
// Latency: AR/AW/R/B are combinational. W takes 1 cycle through the buffer. IRQ takes 2 aclk edges.
// Backpressure: AR/AW stall at MAX_OUTST outstanding bursts. s_axi.wready drops only when the W buffer is full.
// Ports: aclk, areset (sync, active-high), irq_i/irq_o, s_axi (CPU side, slave), m_axi (fabric side, master).
// Optional: define CPU_AXI_BRIDGE_WFENCE_EN to hold W beats until their AW has completed downstream.
module cpu_axi_bridge #(
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_IRQ    = 2,
  parameter int MAX_OUTST  = 4,
  parameter int WBUF_DEPTH = 4
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [NUM_IRQ-1:0] irq_o,
  cpu_axi_bridge_if.slave    s_axi,
  cpu_axi_bridge_if.master   m_axi
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(WBUF_DEPTH + 1);
  localparam int ENT_W  = DATA_W + STRB_W + 1;
  localparam logic [3:0]       LP_MAX   = 4'(MAX_OUTST);
  localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(WBUF_DEPTH);

  // ---------------- read address / data ----------------
  logic [3:0]        r_rd_cnt;
  logic              w_rd_ok, w_ar_hs, w_r_done;
  logic [ID_W-1:0]   w_ar_id;
  logic [ADDR_W-1:0] w_ar_addr;

  assign w_rd_ok   = r_rd_cnt < LP_MAX;
  assign w_ar_id   = s_axi.arid;
  assign w_ar_addr = s_axi.araddr;

  assign m_axi.arvalid = s_axi.arvalid & w_rd_ok;
  assign s_axi.arready = m_axi.arready & w_rd_ok;
  assign m_axi.arid    = w_ar_id;
  assign m_axi.araddr  = w_ar_addr;
  assign m_axi.arlen   = {4'b0, s_axi.arlen};
  assign m_axi.arsize  = s_axi.arsize;
  assign m_axi.arburst = s_axi.arburst;
  assign m_axi.arlock  = s_axi.arlock[0];
  assign m_axi.arcache = s_axi.arcache;
  assign m_axi.arprot  = s_axi.arprot;

  assign s_axi.rid    = m_axi.rid;
  assign s_axi.rdata  = m_axi.rdata;
  assign s_axi.rresp  = m_axi.rresp;
  assign s_axi.rlast  = m_axi.rlast;
  assign s_axi.rvalid = m_axi.rvalid;
  assign m_axi.rready = s_axi.rready;

  assign w_ar_hs  = s_axi.arvalid & s_axi.arready;
  assign w_r_done = m_axi.rvalid & m_axi.rready & m_axi.rlast;

  always_ff @(posedge aclk) begin
    if (areset)                    r_rd_cnt <= 4'd0;
    else if (w_ar_hs && !w_r_done) r_rd_cnt <= r_rd_cnt + 4'd1;
    else if (!w_ar_hs && w_r_done) r_rd_cnt <= r_rd_cnt - 4'd1;
  end

  // ---------------- write address / response ----------------
  logic [3:0] r_wr_cnt;
  logic       w_wr_ok, w_aw_hs, w_b_done;

  assign w_wr_ok = r_wr_cnt < LP_MAX;

  assign m_axi.awvalid = s_axi.awvalid & w_wr_ok;
  assign s_axi.awready = m_axi.awready & w_wr_ok;
  assign m_axi.awid    = s_axi.awid;
  assign m_axi.awaddr  = s_axi.awaddr;
  assign m_axi.awlen   = {4'b0, s_axi.awlen};
  assign m_axi.awsize  = s_axi.awsize;
  assign m_axi.awburst = s_axi.awburst;
  assign m_axi.awlock  = s_axi.awlock[0];
  assign m_axi.awcache = s_axi.awcache;
  assign m_axi.awprot  = s_axi.awprot;

  assign s_axi.bid    = m_axi.bid;
  assign s_axi.bresp  = m_axi.bresp;
  assign s_axi.bvalid = m_axi.bvalid;
  assign m_axi.bready = s_axi.bready;

  assign w_aw_hs  = s_axi.awvalid & s_axi.awready;
  assign w_b_done = m_axi.bvalid & m_axi.bready;

  always_ff @(posedge aclk) begin
    if (areset)                     r_wr_cnt <= 4'd0;
    else if (w_aw_hs && !w_b_done)  r_wr_cnt <= r_wr_cnt + 4'd1;
    else if (!w_aw_hs && w_b_done)  r_wr_cnt <= r_wr_cnt - 4'd1;
  end

  // ---------------- write data buffer ----------------
  logic [ENT_W-1:0]  r_mem [WBUF_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_wcnt;
  logic [ENT_W-1:0]  w_head;
  logic              w_full, w_empty, w_push, w_pop;

  assign w_full  = (r_wcnt == LP_DEPTH);
  assign w_empty = (r_wcnt == '0);
  // wready depends only on the registered fill level, never on m_axi.wready.
  assign s_axi.wready = !w_full;
  assign w_push = s_axi.wvalid & !w_full;
  assign w_pop  = m_axi.wvalid & m_axi.wready;

  assign w_head      = r_mem[r_rd_ptr];
  assign m_axi.wdata = w_head[ENT_W-1 -: DATA_W];
  assign m_axi.wstrb = w_head[STRB_W:1];
  assign m_axi.wlast = w_head[0];
  assign m_axi.wid   = '0;

  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s_axi.wdata, s_axi.wstrb, s_axi.wlast};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_wcnt   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_wcnt <= r_wcnt + CNT_W'(1);
      else if (!w_push && w_pop) r_wcnt <= r_wcnt - CNT_W'(1);
    end
  end

`ifdef CPU_AXI_BRIDGE_WFENCE_EN
  // Bursts whose AW is accepted downstream but whose wlast has not yet left.
  // Bounded by r_wr_cnt, because B cannot return before the burst's data has gone out.
  logic [3:0] r_aw_pend;
  logic       w_wl_pop;

  assign w_wl_pop     = w_pop & m_axi.wlast;
  assign m_axi.wvalid = !w_empty & (r_aw_pend != 4'd0);

  always_ff @(posedge aclk) begin
    if (areset)                     r_aw_pend <= 4'd0;
    else if (w_aw_hs && !w_wl_pop)  r_aw_pend <= r_aw_pend + 4'd1;
    else if (!w_aw_hs && w_wl_pop)  r_aw_pend <= r_aw_pend - 4'd1;
  end
`else
  assign m_axi.wvalid = !w_empty;
`endif

  // ---------------- interrupt synchroniser ----------------
  logic [NUM_IRQ-1:0] r_irq_s1, r_irq_s2;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_irq_s1 <= '0;
      r_irq_s2 <= '0;
    end else begin
      r_irq_s1 <= irq_i;
      r_irq_s2 <= r_irq_s1;
    end
  end
  assign irq_o = r_irq_s2;

  // AXI4 has no WID, and only lock[0] (exclusive) survives the mapping.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, s_axi.wid, s_axi.arlock[1], s_axi.awlock[1]};
endmodule
